wb_trace_fifo: RTL and testbench

WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

---
 rtl/wb_trace_fifo.sv | 113 +++++++++++
 tb/tb_wb_trace_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// Register-write trace FIFO: captures regfile writes with a cycle stamp.
// Define WB_TRACE_STAMP_EN to build the cycle counter and stamp storage.
module wb_trace_fifo #(
  parameter int DEPTH   = 8,
  parameter int STAMP_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_writeEnable,
  input  logic [4:0]         ctrl_writeReg,
  input  logic [31:0]        data_writeReg,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [4:0]         trace_reg,
  output logic [31:0]        trace_data,
  output logic [STAMP_W-1:0] trace_stamp,
  output logic               full,
  output logic [7:0]         drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [7:0]    drop_q, drop_d;
  logic [AW-1:0] waddr, raddr;

  logic [4:0]  reg_mem  [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic empty;
  logic push;
  logic pop;
  logic accept;

  assign waddr = wptr_q[AW-1:0];
  assign raddr = rptr_q[AW-1:0];

  // Extra MSB on each pointer separates full from empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (waddr == raddr);

  assign push   = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
  assign pop    = !empty && trace_ready;
  assign accept = push && (!full || pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    drop_d = drop_q;
    if (accept) begin
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (push && full && !pop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      drop_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && accept) begin
      reg_mem[waddr]  <= ctrl_writeReg;
      data_mem[waddr] <= data_writeReg;
    end
  end

  assign trace_valid = !empty;
  assign trace_reg   = empty ? 5'd0  : reg_mem[raddr];
  assign trace_data  = empty ? 32'd0 : data_mem[raddr];
  assign drop_count  = drop_q;

`ifdef WB_TRACE_STAMP_EN
  logic [STAMP_W-1:0] cnt_q, cnt_d;
  logic [STAMP_W-1:0] stamp_mem [DEPTH];

  assign cnt_d = cnt_q + {{(STAMP_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A push stores the counter value held before its own edge.
  always_ff @(posedge clock) begin
    if (reset && accept) begin
      stamp_mem[waddr] <= cnt_q;
    end
  end

  assign trace_stamp = empty ? '0 : stamp_mem[raddr];
`else
  assign trace_stamp = '0;
`endif

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Randomized and directed bench for wb_trace_fifo against a queue model.
module tb_wb_trace_fifo;
  localparam int DEPTH = 8;
  localparam int SW    = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          we    = 1'b0;
  logic [4:0]    wr    = '0;
  logic [31:0]   wd    = '0;
  logic          rdy   = 1'b0;
  logic          t_valid;
  logic [4:0]    t_reg;
  logic [31:0]   t_data;
  logic [SW-1:0] t_stamp;
  logic          t_full;
  logic [7:0]    t_drop;

  always #5 clock = ~clock;

  wb_trace_fifo #(.DEPTH(DEPTH), .STAMP_W(SW)) dut (
    .clock(clock),
    .reset(reset),
    .ctrl_writeEnable(we),
    .ctrl_writeReg(wr),
    .data_writeReg(wd),
    .trace_valid(t_valid),
    .trace_ready(rdy),
    .trace_reg(t_reg),
    .trace_data(t_data),
    .trace_stamp(t_stamp),
    .full(t_full),
    .drop_count(t_drop)
  );

  typedef struct packed {
    logic [4:0]    r;
    logic [31:0]   d;
    logic [SW-1:0] s;
  } ent_t;

  ent_t q[$];
  int   cnt;
  int   drops;
  int   n_cmp;
  int   n_bad;

  function automatic logic [SW-1:0] exp_s(input logic [SW-1:0] v);
`ifdef WB_TRACE_STAMP_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: apply one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit   do_push, do_pop, was_full;
    ent_t e;
    if (!reset) begin
      q.delete();
      cnt   = 0;
      drops = 0;
      return;
    end
    do_push  = we && (wr != 5'd0);
    do_pop   = (q.size() > 0) && rdy;
    was_full = (q.size() == DEPTH);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      if (!was_full || do_pop) begin
        e.r = wr;
        e.d = wd;
        e.s = SW'(cnt);
        q.push_back(e);
      end else if (drops < 255) begin
        drops++;
      end
    end
    cnt = (cnt + 1) % (1 << SW);
  endtask

  task automatic compare();
    ent_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk("valid", 64'(t_valid), 64'(q.size() > 0));
    chk("reg",   64'(t_reg),   64'(h.r));
    chk("data",  64'(t_data),  64'(h.d));
    chk("stamp", 64'(t_stamp), 64'(exp_s(h.s)));
    chk("full",  64'(t_full),  64'(q.size() == DEPTH));
    chk("drop",  64'(t_drop),  64'(drops));
  endtask

  task automatic cyc(input logic e, input logic [4:0] r,
                     input logic [31:0] d, input logic rd,
                     input logic rs);
    we    = e;
    wr    = r;
    wd    = d;
    rdy   = rd;
    reset = rs;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
  endtask

  task automatic drain();
    for (int g = 0; g < 2 * DEPTH && q.size() > 0; g++) begin
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    logic [SW-1:0] ws [6];
    int guard;
    int bias;
    n_cmp = 0;
    n_bad = 0;
    cnt   = 0;
    drops = 0;

    cyc(1'b1, 5'd4, 32'h1234, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_valid", 64'(t_valid), 64'd0);
    chk("rst_full",  64'(t_full),  64'd0);
    chk("rst_drop",  64'(t_drop),  64'd0);
    chk("rst_data",  64'(t_data),  64'd0);

    for (int i = 0; i < 5; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b1, 5'd3, 32'h0000_00AA, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("r3_valid", 64'(t_valid), 64'd1);
      chk("r3_reg",   64'(t_reg),   64'd3);
      chk("r3_data",  64'(t_data),  64'hAA);
      chk("r3_stamp", 64'(t_stamp), 64'(exp_s(16'd5)));
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    end
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    chk("r3_popped", 64'(t_valid), 64'd0);

    cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("r0_valid", 64'(t_valid), 64'd0);
    chk("r0_drop",  64'(t_drop),  64'd0);

    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 5'(i), 32'(i * 32'h11), 1'b0, 1'b1);
      if (i == 8) chk("ovf_full8", 64'(t_full), 64'd1);
    end
    chk("ovf_drop2", 64'(t_drop), 64'd2);
    for (int k = 1; k <= 8; k++) begin
      chk("ovf_order", 64'(t_reg), 64'(k));
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    end
    chk("ovf_empty", 64'(t_valid), 64'd0);

    for (int i = 1; i <= 8; i++) cyc(1'b1, 5'(i), 32'(i), 1'b0, 1'b1);
    cyc(1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
    chk("pp_full", 64'(t_full), 64'd1);
    chk("pp_drop", 64'(t_drop), 64'd2);
    for (int k = 2; k <= 9; k++) begin
      chk("pp_order", 64'(t_reg), 64'(k));
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    end

    for (int i = 1; i <= 4; i++) cyc(1'b1, 5'(i), 32'(i), 1'b0, 1'b1);
    cyc(1'b1, 5'd5, 32'h55, 1'b1, 1'b0);
    chk("mr_valid", 64'(t_valid), 64'd0);
    chk("mr_drop",  64'(t_drop),  64'd0);
    cyc(1'b1, 5'd7, 32'h77, 1'b1, 1'b1);
    chk("mr_reg",   64'(t_reg),   64'd7);
    chk("mr_stamp", 64'(t_stamp), 64'(exp_s(16'd0)));
    drain();

    for (int i = 0; i < DEPTH + 300; i++) begin
      cyc(1'b1, 5'(1 + i % 31), $urandom, 1'b0, 1'b1);
    end
    chk("sat_drop", 64'(t_drop), 64'd255);
    drain();

    guard = 0;
    while (cnt != 16'hFFFD && guard < 70000) begin
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      guard++;
    end
    chk("wrap_reach", 64'(cnt), 64'hFFFD);
    ws = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
    for (int i = 0; i < 6; i++) cyc(1'b1, 5'(i + 1), 32'(i), 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("wrap_stamp", 64'(t_stamp), 64'(exp_s(ws[i])));
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    end

    for (int blk = 0; blk < 6; blk++) begin
      bias = blk % 3;
      for (int i = 0; i < 500; i++) begin
        cyc(1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)),
            $urandom,
            1'($urandom_range(0, 3) < bias + 1),
            1'($urandom_range(0, 199) != 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
